// File: rtl/unidad_ejecucion_pkg.sv
// Shared widths, opcodes and state encoding for the execute stage.
package unidad_ejecucion_pkg;

    localparam int WIDTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int CNT_W    = 3;
    localparam int MUL_ITER = 8;

    // Iteration counter counts down; MUL ends when it reaches zero.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_WB   = 2'b11
    } state_e;

endpackage

// File: rtl/unidad_ejecucion_if.sv
// Control-unit / register-file side signals of the execute stage.
interface unidad_ejecucion_if;
    import unidad_ejecucion_pkg::*;

    logic              start;
    logic [2:0]        op;
    logic [ADDR_W-1:0] dest;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic              busy;
    logic              done;
    logic              w;
    logic [ADDR_W-1:0] sw;
    logic [WIDTH-1:0]  c_out;
    logic              zero;
    logic              carry;

    modport master (
        output start, op, dest, a_in, b_in,
        input  busy, done, w, sw, c_out, zero, carry
    );

    modport slave (
        input  start, op, dest, a_in, b_in,
        output busy, done, w, sw, c_out, zero, carry
    );

endinterface

// File: rtl/unidad_ejecucion_alu_comb.sv
// Single-cycle ALU core: add/sub/logic/shift with carry flag. MUL is not
// handled here; it returns zero for that opcode.
module alu_comb
    import unidad_ejecucion_pkg::*;
(
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Opcode select; diff[WIDTH] is the borrow, set exactly when a < b.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin result = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
            OP_SUB: begin result = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin result = {a[WIDTH-2:0], 1'b0}; carry = a[WIDTH-1]; end
            OP_SHR: begin result = {1'b0, a[WIDTH-1:1]}; carry = a[0];       end
            default: begin result = '0; carry = 1'b0; end
        endcase
    end

endmodule

// File: rtl/unidad_ejecucion.sv
// Multi-cycle execute stage feeding the register-file write port.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last write-back values
// EXEC  | one-cycle ALU evaluation on latched operands
// MUL   | 8-cycle shift-add multiply, one multiplier bit per cycle
// WB    | w/done pulse; sw, c_out, zero, carry carry the new result
module unidad_ejecucion
    import unidad_ejecucion_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    unidad_ejecucion_if.slave  bus
);

    state_e                state_q, state_d;
    op_e                   op_q;
    logic [ADDR_W-1:0]     dest_q;
    logic [WIDTH-1:0]      a_q, b_q;

    logic [2*WIDTH-1:0]    acc_q, mcand_q, acc_next;
    logic [WIDTH-1:0]      mplier_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  load, step, wb_load;
    logic [WIDTH-1:0]      wb_result, alu_result;
    logic                  wb_carry, alu_carry;

    logic                  busy_q, done_q, w_q, zero_q, carry_q;
    logic [ADDR_W-1:0]     sw_q;
    logic [WIDTH-1:0]      c_out_q;

    alu_comb u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        wb_load   = 1'b0;
        wb_result = alu_result;
        wb_carry  = alu_carry;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = (op_e'(bus.op) == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                wb_load = 1'b1;
                state_d = ST_WB;
            end
            ST_MUL: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    wb_load   = 1'b1;
                    wb_result = acc_next[WIDTH-1:0];
                    wb_carry  = |acc_next[2*WIDTH-1:WIDTH];
                    state_d   = ST_WB;
                end
            end
            ST_WB: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch and shift-add multiplier datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_ADD;
            dest_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            op_q     <= op_e'(bus.op);
            dest_q   <= bus.dest;
            a_q      <= bus.a_in;
            b_q      <= bus.b_in;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, bus.a_in};
            mplier_q <= bus.b_in;
            cnt_q    <= CNT_LAST;
        end else if (step) begin
            acc_q    <= acc_next;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - 1'b1;
        end
    end

    // Registered outputs; result fields only change on entry to WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            w_q     <= 1'b0;
            sw_q    <= '0;
            c_out_q <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            w_q    <= (state_d == ST_WB);
            done_q <= (state_d == ST_WB);
            if (wb_load) begin
                sw_q    <= dest_q;
                c_out_q <= wb_result;
                zero_q  <= (wb_result == '0);
                carry_q <= wb_carry;
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.w     = w_q;
    assign bus.sw    = sw_q;
    assign bus.c_out = c_out_q;
    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_unidad_ejecucion.sv
// Directed-vector bench for the execute stage.
module tb_unidad_ejecucion;
    import unidad_ejecucion_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    unidad_ejecucion_if bus ();

    unidad_ejecucion dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        op_e        op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] d;
        logic [7:0] c;
        logic       z;
        logic       cy;
        int         lat;
        int         glitch;
    } vec_t;

    vec_t vecs[14];

    // Window statistics gathered by observe().
    int         w_cnt, done_cnt, busy_cnt, w_first, busy_last, dw_err;
    logic [7:0] cap_c;
    logic [2:0] cap_sw;
    logic       cap_z, cap_cy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input op_e op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.dest  = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Samples cycles 1..12 after the accepting edge.
    task automatic observe(input int glitch);
        w_cnt = 0; done_cnt = 0; busy_cnt = 0; w_first = 0; busy_last = 0; dw_err = 0;
        cap_c = '0; cap_sw = '0; cap_z = 1'b0; cap_cy = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (bus.busy) begin busy_cnt++; busy_last = cyc; end
            if (bus.done) done_cnt++;
            if (bus.done !== bus.w) dw_err++;
            if (bus.w) begin
                w_cnt++;
                if (w_first == 0) w_first = cyc;
                cap_c = bus.c_out; cap_sw = bus.sw; cap_z = bus.zero; cap_cy = bus.carry;
            end
            if (glitch != 0 && cyc == glitch) begin
                bus.start = 1'b1; bus.op = OP_ADD; bus.a_in = 8'h55; bus.b_in = 8'hAA;
            end
            if (glitch != 0 && cyc == glitch + 1) bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 3'd5, 8'h10, 1'b0, 1'b1, 2, 0};
        vecs[1]  = '{OP_SUB, 8'h03, 8'h03, 3'd1, 8'h00, 1'b1, 1'b0, 2, 0};
        vecs[2]  = '{OP_SUB, 8'h02, 8'h03, 3'd2, 8'hFF, 1'b0, 1'b1, 2, 0};
        vecs[3]  = '{OP_SHL, 8'h81, 8'h00, 3'd3, 8'h02, 1'b0, 1'b1, 2, 0};
        vecs[4]  = '{OP_AND, 8'hF0, 8'h3C, 3'd4, 8'h30, 1'b0, 1'b0, 2, 0};
        vecs[5]  = '{OP_OR,  8'hF0, 8'h0F, 3'd6, 8'hFF, 1'b0, 1'b0, 2, 0};
        vecs[6]  = '{OP_XOR, 8'hAA, 8'hAA, 3'd0, 8'h00, 1'b1, 1'b0, 2, 0};
        vecs[7]  = '{OP_SHR, 8'h81, 8'h00, 3'd7, 8'h40, 1'b0, 1'b1, 2, 0};
        vecs[8]  = '{OP_ADD, 8'hFF, 8'h01, 3'd1, 8'h00, 1'b1, 1'b1, 2, 0};
        vecs[9]  = '{OP_SHR, 8'h02, 8'h00, 3'd2, 8'h01, 1'b0, 1'b0, 2, 0};
        vecs[10] = '{OP_MUL, 8'd13, 8'd11, 3'd2, 8'h8F, 1'b0, 1'b0, 9, 0};
        vecs[11] = '{OP_MUL, 8'd16, 8'd16, 3'd3, 8'h00, 1'b1, 1'b1, 9, 0};
        vecs[12] = '{OP_MUL, 8'hFF, 8'hFF, 3'd4, 8'h01, 1'b0, 1'b1, 9, 0};
        vecs[13] = '{OP_MUL, 8'd13, 8'd11, 3'd6, 8'h8F, 1'b0, 1'b0, 9, 3};

        // Reset asserted with start high: nothing may happen.
        bus.start = 1'b1; bus.op = OP_ADD; bus.a_in = 8'h01; bus.b_in = 8'h01; bus.dest = 3'd1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_w",     32'(bus.w),     32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_sw",    32'(bus.sw),    32'd0);
        check("rst_c_out", 32'(bus.c_out), 32'd0);
        check("rst_zero",  32'(bus.zero),  32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d);
            observe(vecs[i].glitch);
            check($sformatf("v%0d_w_cnt", i),     32'(w_cnt),     32'd1);
            check($sformatf("v%0d_done_cnt", i),  32'(done_cnt),  32'd1);
            check($sformatf("v%0d_done_eq_w", i), 32'(dw_err),    32'd0);
            check($sformatf("v%0d_wb_cycle", i),  32'(w_first),   32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cnt", i),  32'(busy_cnt),  32'(vecs[i].lat));
            check($sformatf("v%0d_busy_last", i), 32'(busy_last), 32'(vecs[i].lat));
            check($sformatf("v%0d_c_out", i),     32'(cap_c),     32'(vecs[i].c));
            check($sformatf("v%0d_sw", i),        32'(cap_sw),    32'(vecs[i].d));
            check($sformatf("v%0d_zero", i),      32'(cap_z),     32'(vecs[i].z));
            check($sformatf("v%0d_carry", i),     32'(cap_cy),    32'(vecs[i].cy));
            check($sformatf("v%0d_hold_c", i),    32'(bus.c_out), 32'(vecs[i].c));
            check($sformatf("v%0d_hold_sw", i),   32'(bus.sw),    32'(vecs[i].d));
        end

        // Back-to-back: second start in the first cycle busy is low.
        issue(OP_ADD, 8'h01, 8'h02, 3'd1);
        @(posedge clk); #1;
        check("b2b_first_w", 32'(bus.w), 32'd1);
        check("b2b_first_c", 32'(bus.c_out), 32'h03);
        @(posedge clk); #1;
        check("b2b_busy_low", 32'(bus.busy), 32'd0);
        issue(OP_XOR, 8'h0F, 8'hFF, 3'd2);
        observe(0);
        check("b2b_second_wb_cycle", 32'(w_first), 32'd2);
        check("b2b_second_c", 32'(cap_c), 32'hF0);
        check("b2b_second_sw", 32'(cap_sw), 32'd2);

        // Reset in MUL cycle 4: immediate idle, no write, outputs cleared.
        issue(OP_MUL, 8'd13, 8'd11, 3'd5);
        repeat (3) begin @(posedge clk); #1; end
        check("mrst_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_w", 32'(bus.w), 32'd0);
        check("mrst_c_out", 32'(bus.c_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        observe(0);
        check("mrst_no_w", 32'(w_cnt), 32'd0);
        check("mrst_no_busy", 32'(busy_cnt), 32'd0);

        issue(OP_ADD, 8'h01, 8'h01, 3'd7);
        observe(0);
        check("post_rst_w_cnt", 32'(w_cnt), 32'd1);
        check("post_rst_wb_cycle", 32'(w_first), 32'd2);
        check("post_rst_c_out", 32'(cap_c), 32'h02);
        check("post_rst_sw", 32'(cap_sw), 32'd7);
        check("post_rst_carry", 32'(cap_cy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
